// File: rtl/qu_uop_dispatch_buffer.sv
// rtl/qu_uop_dispatch_buffer.sv - In-order micro-op dispatch buffer steering uops to the int/control or load/store issue port
//
// Purpose:
//   A circular FIFO of DEPTH packed micro-ops (67 bits each) sits between decode and
//   the issue queues. The head entry is classified by optype = uop[2:0]:
//     3'b001 / 3'b011 (INT / CONT)    -> ic port
//     3'b101 / 3'b111 (LOAD / STORE)  -> ldst port
//     bit 0 == 0                      -> illegal, dropped with a one-cycle illegal_o pulse
//   Dispatch is strictly in order, so a stalled head blocks all younger entries.
//   flush_i clears the pointers and the occupancy on the next edge and takes priority
//   over every enqueue and dequeue in that cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_i                     discard all buffered micro-ops
//   in_valid_i/in_ready_o       decode handshake, in_uop_i carries the packed uop
//   ic_valid_o/ic_ready_i       integer/control issue handshake, ic_uop_o = head bits
//   ldst_valid_o/ldst_ready_i   load/store issue handshake, ldst_uop_o = head bits
//   illegal_o                   pulse when an illegal head entry is dropped
//   count_o                     current occupancy, 0..DEPTH
//
// Configuration macro:
//   QU_DISPATCH_BYPASS_EN - when defined and the buffer is empty, the incoming uop is
//   presented on the dispatch outputs in the same cycle and, if consumed, never written.

module qu_uop_dispatch_buffer #(
    parameter int DEPTH     = 8,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [66:0]          in_uop_i,
    output logic                 ic_valid_o,
    input  logic                 ic_ready_i,
    output logic [66:0]          ic_uop_o,
    output logic                 ldst_valid_o,
    input  logic                 ldst_ready_i,
    output logic [66:0]          ldst_uop_o,
    output logic                 illegal_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [66:0]          mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;

    logic                 empty;
    logic                 bypass_sel;
    logic                 disp_present;
    logic [66:0]          disp_uop;
    logic                 fire;
    logic                 enq;
    logic                 fifo_push;
    logic                 fifo_pop;

    assign empty = (count == '0);

`ifdef QU_DISPATCH_BYPASS_EN
    // With nothing buffered the incoming uop is the oldest one, so it may be
    // offered to the issue ports directly.
    assign bypass_sel = empty;
`else
    assign bypass_sel = 1'b0;
`endif

    assign disp_uop     = bypass_sel ? in_uop_i : mem[rd_ptr];
    assign disp_present = !flush_i && (bypass_sel ? in_valid_i : !empty);

    assign ic_valid_o   = disp_present &&  disp_uop[0] && !disp_uop[2];
    assign ldst_valid_o = disp_present &&  disp_uop[0] &&  disp_uop[2];
    assign illegal_o    = disp_present && !disp_uop[0];

    assign ic_uop_o     = disp_uop;
    assign ldst_uop_o   = disp_uop;
    assign count_o      = count;

    assign fire = (ic_valid_o && ic_ready_i) || (ldst_valid_o && ldst_ready_i) || illegal_o;

    // A full buffer refuses input even if the head leaves this cycle; this keeps
    // in_ready_o independent of the issue-side readies.
    assign in_ready_o = (count < CNT_WIDTH'(DEPTH)) && !flush_i;
    assign enq        = in_valid_i && in_ready_o;

    // A bypassed uop that is consumed at once never touches the storage.
    assign fifo_push  = enq && !(bypass_sel && fire);
    assign fifo_pop   = fire && !bypass_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_WIDTH'(fifo_push) - CNT_WIDTH'(fifo_pop);
        end
    end

    // Entry storage is deliberately left uninitialised by reset and flush.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            mem[wr_ptr] <= in_uop_i;
        end
    end

endmodule

// File: doc/qu_uop_dispatch_buffer.md
# qu_uop_dispatch_buffer

In-order micro-op buffer between the decoder and the issue queues. It accepts packed `uop_t` micro-ops from decode through a valid/ready handshake and holds them in a circular FIFO. It steers each head entry by `optype` to either the integer/control issue port or the load/store issue port. It also discards illegal micro-ops and supports a pipeline flush.

## Interface
- `DEPTH`, 8: FIFO entries; a power of two, minimum 2.
- `CNT_WIDTH`, $clog2(DEPTH)+1: occupancy counter width.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: discard all buffered micro-ops.
- `in_valid_i` in 1: decode presents a micro-op.
- `in_ready_o` out 1: buffer accepts the micro-op this cycle.
- `in_uop_i` in UOP_WIDTH (67): packed `uop_t`.
- `ic_valid_o` out 1: the head is an `OPTYPE_INT` or `OPTYPE_CONT` micro-op.
- `ic_ready_i` in 1: the integer/control issue queue accepts.
- `ic_uop_o` out 67: the head micro-op, viewed as `uop_ic`.
- `ldst_valid_o` out 1: the head is an `OPTYPE_LOAD` or `OPTYPE_STORE` micro-op.
- `ldst_ready_i` in 1: the load/store issue queue accepts.
- `ldst_uop_o` out 67: the head micro-op, viewed as `uop_ldst`.
- `illegal_o` out 1: single-cycle pulse when an illegal head entry is dropped.
- `count_o` out CNT_WIDTH: current occupancy.

## Operation
- Storage is DEPTH×67 bits, with a write pointer and a read pointer of $clog2(DEPTH) bits that wrap modulo DEPTH. `count` is held in a separate register from 0 to DEPTH.
- Enqueue occurs when `in_valid_i && in_ready_o`.
  - `in_ready_o = (count < DEPTH) && !flush_i`.
  - Enqueue while full is not permitted, even when a dequeue happens in the same cycle.
- Head classification uses `optype = head[2:0]`:
  - 3'b001 or 3'b011 routes to the ic port.
  - 3'b101 or 3'b111 routes to the ldst port.
  - Any value with bit 0 == 0 is illegal.
- At most one of `ic_valid_o`, `ldst_valid_o` and `illegal_o` is high in a cycle. All three are 0 when empty or when `flush_i` is high.
- Dequeue occurs on any of the following:
  - `ic_valid_o && ic_ready_i`;
  - `ldst_valid_o && ldst_ready_i`;
  - `illegal_o`, which pops unconditionally.
- Dispatch is strictly in order. A stalled head blocks younger entries even if they target the other port.
- `ic_uop_o` and `ldst_uop_o` both carry the raw head bits at all times. Only the valid signals differ.
- Counter update: `count += enq - deq`. A simultaneous enqueue and dequeue leaves `count` unchanged.
- Flush takes priority over every other action. On the next edge:
  - both pointers and `count` become 0;
  - any enqueue or dequeue in that cycle is ignored.
- Reset mid-operation clears the FIFO exactly as flush does, asynchronously.
- Entry contents are not cleared by reset or flush.

## Timing
- Reset values:
  - `count_o` = 0, so `in_ready_o` = 1 provided `flush_i` is 0.
  - `ic_valid_o`, `ldst_valid_o` and `illegal_o` = 0.
  - Uop outputs are don't-care while their valid is 0.
- Enqueue-to-dispatch latency is 1 cycle. A micro-op accepted at edge N is presented at the head after edge N.
- Outputs are combinational from registered state. They do not depend combinationally on `ic_ready_i` or `ldst_ready_i`.
- `in_ready_o` depends combinationally only on `count` and `flush_i`.
- Throughput is one micro-op per cycle in and one out.
- Valid-hold rule: once `ic_valid_o` or `ldst_valid_o` is asserted, it and its uop stay stable until the handshake completes or a flush occurs.

## Configuration
- `QU_DISPATCH_BYPASS_EN` defined:
  - When `count == 0`, the incoming micro-op is classified and presented on the ic/ldst/illegal outputs in the same cycle.
  - If the target port accepts (or the micro-op is illegal), it is consumed without being written and `count` stays 0.
  - Otherwise it is written normally.
  - Enqueue-to-dispatch latency becomes 0 when empty.
  - Flush suppresses the bypass.
- `QU_DISPATCH_BYPASS_EN` undefined: no combinational path from `in_*` to the outputs, and latency is always 1 cycle.

## Test plan
- Reset, then enqueue an INT uop with imm=32'h0000_0005 and rd=7'd3 while holding `ic_ready_i`=1. Required: `ic_valid_o` rises 1 cycle after acceptance (0 cycles with bypass), `ic_uop_o` matches the input, and `count_o` returns to 0.
- Enqueue LOAD, INT, STORE with `ldst_ready_i`=0 and `ic_ready_i`=1. Required: `ldst_valid_o` stays high and `ic_valid_o` stays 0 (in-order blocking). After `ldst_ready_i`=1, the three uops exit in order LOAD, INT, STORE.
- Fill 8 uops with both readies at 0. Required: `count_o`=8 and `in_ready_o`=0. Drain one; the next cycle shows `in_ready_o`=1. Then push 8 more through to check pointer wrap-around and data ordering.
- Enqueue a uop with optype 3'b010, followed by a CONT uop. Required: `illegal_o` pulses for one cycle, `count_o` decrements, and the CONT uop then appears on the ic port.
- With 5 entries buffered, assert `flush_i` for one cycle while `in_valid_i`=1. Required: `in_ready_o`=0 and all valids are 0 during the flush cycle, and `count_o`=0 afterwards.
- With 3 entries buffered, assert `rst_n` low in the middle of a cycle. Required: `count_o` drops to 0 and all valids fall immediately, without waiting for a clock edge.
